mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Multicycle integer multiply/divide unit for the MIPS datapath (mult/div, optionally multu/divu).
//  Sits beside the ALU: operands come from the A/B registers; results land in HI/LO, which feed MemToReg (mfhi/mflo).
//  The control unit holds its FSM in a wait state while busy=1 and advances on done.
// PARAMETERS
//  WIDTH  32  operand width; hi/lo are WIDTH bits each; must be >=4
// PORTS
//  clock       in   1      system clock, rising edge
//  reset       in   1      synchronous, active-high reset
//  start       in   1      request; sampled only while busy=0
//  op          in   2      00 MULT, 01 DIV, 10 MULTU, 11 DIVU
//  src_a       in   WIDTH  multiplicand / dividend
//  src_b       in   WIDTH  multiplier / divisor
//  busy        out  1      high from accepting edge until done cycle inclusive
//  done        out  1      one-cycle pulse; hi/lo valid in this cycle
//  div_zero    out  1      pulses with done when a DIV/DIVU had src_b==0
//  illegal_op  out  1      one-cycle pulse, unsupported op rejected
//  hi          out  WIDTH  HI register (product upper / remainder)
//  lo          out  WIDTH  LO register (product lower / quotient)
// BEHAVIOUR
//  - Reset: state IDLE, busy=done=div_zero=illegal_op=0, hi=lo=0, counter=0. Reset mid-operation aborts; no done.
//  - FSM: IDLE -> MUL | DIV | DONE; MUL -> DONE after WIDTH+1 steps; DIV -> DONE after WIDTH steps; DONE -> IDLE.
//  - Accept: start=1 in IDLE with legal op; operands latched at that edge; later src_a/src_b changes ignored.
//  - start while busy=1 is ignored, not queued. start in the DONE cycle is ignored (busy still 1).
//  - MUL: radix-2 Booth over WIDTH+1-bit operands. Extension: sign for MULT, zero for MULTU.
//    2*WIDTH+2-bit product register; one step per cycle.
//  - MUL timing: done high exactly WIDTH+2 cycles after the accepting edge.
//  - MUL result: hi=product[2W-1:W], lo=product[W-1:0].
//  - DIV: restoring division on magnitudes; one quotient bit per cycle.
//  - DIV timing: done high exactly WIDTH+1 cycles after the accepting edge.
//  - DIV signs (DIV): quotient negated if sign(a)^sign(b); remainder takes sign(a). lo=quotient, hi=remainder.
//    All arithmetic is mod 2^WIDTH, so MIN/-1 gives lo=MIN, hi=0 with no flag.
//  - Divide by zero (src_b==0, DIV/DIVU): IDLE->DONE directly.
//    done=div_zero=1 one cycle after accept; hi/lo keep prior values.
//  - hi/lo are written only on the edge entering DONE (except div-by-zero). They hold otherwise.
//  - done, div_zero and illegal_op never overlap a new accept; each is high for exactly one cycle.
// CONFIGURATION
//  - MULTDIV_UNSIGNED_EN defined: ops 10/11 perform MULTU/DIVU. MULTU zero-extends; DIVU skips sign correction.
//  - MULTDIV_UNSIGNED_EN undefined: ops 10/11 are illegal.
//    illegal_op pulses the cycle after the request; state stays IDLE; busy stays 0; hi/lo unchanged.
// STRUCTURE
//  - Package multdiv_pkg:
//    - op_t enum (OP_MULT, OP_DIV, OP_MULTU, OP_DIVU)
//    - state_t enum (IDLE, MUL, DIV, DONE)
//    - localparam function for counter width $clog2(WIDTH+2)
//  - Sub-module restoring_div_step (combinational): given partial remainder, next dividend bit and divisor,
//    returns next remainder and quotient bit. Instantiated once.
//  - Booth step is inline in mult_div_unit.
// TESTING (WIDTH=32)
//  1. MULT a=7, b=0xFFFFFFFD (-3) -> done at +34 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high 34 cycles.
//  2. DIV a=0xFFFFFFF9 (-7), b=2 -> done at +33; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
//  3. DIV with preloaded hi=0x11, lo=0x22; a=5, b=0 -> done=div_zero=1 at +1; hi=0x11, lo=0x22 unchanged.
//  4. DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
//  5. MULT started, reset at cycle +10 -> busy=0, hi=lo=0, no done.
//     Second start later: a=3, b=4 gives lo=12, hi=0 at +34.
//     Also: start pulses while busy are ignored.
//  6. op=MULTU a=0xFFFFFFFF, b=2:
//     - with MULTDIV_UNSIGNED_EN: hi=1, lo=0xFFFFFFFE at +34.
//     - without it: illegal_op pulse at +1, busy=0, hi/lo unchanged.

Source files
------------

// File: rtl/multdiv_pkg.sv
// Shared types and sizing helpers for the multicycle multiply/divide unit.
package multdiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_DIV   = 2'b01,
    OP_MULTU = 2'b10,
    OP_DIVU  = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    DONE
  } state_t;

  // Step counter must reach WIDTH for the multiplier's WIDTH+1 Booth steps.
  function automatic int cnt_width(input int w);
    return $clog2(w + 2);
  endfunction

endpackage

// File: rtl/mult_div_restoring_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module restoring_div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // rem_in < divisor, so shifted < 2*divisor and the trial MSB is a clean borrow flag.
  always_comb begin
    shifted = {rem_in, bit_in};
    trial   = shifted - {1'b0, divisor};
    q_bit   = ~trial[WIDTH];
    rem_out = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle MULT/DIV unit writing HI/LO; ops 10/11 (MULTU/DIVU) are legal only
// when MULTDIV_UNSIGNED_EN is defined, otherwise they raise illegal_op.
module mult_div_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             illegal_op,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [2*WIDTH+1:0]  prod;
  logic                qm1;
  logic [WIDTH:0]      mcand;
  logic [WIDTH-1:0]    rem, dvd, dvs;
  logic                neg_q, neg_r;

  op_t                 opc;
  logic                op_legal, op_signed, op_isdiv;
  logic [WIDTH-1:0]    a_mag, b_mag;
  logic [WIDTH:0]      upper, booth_sum;
  logic [2*WIDTH+1:0]  prod_nxt;
  logic [WIDTH-1:0]    rem_nxt, q_final, quot_s, rem_s;
  logic                q_bit;

  always_comb begin
    opc       = op_t'(op);
    op_signed = (opc == OP_MULT) || (opc == OP_DIV);
    op_isdiv  = (opc == OP_DIV) || (opc == OP_DIVU);
`ifdef MULTDIV_UNSIGNED_EN
    op_legal  = 1'b1;
`else
    op_legal  = op_signed;
`endif
    a_mag = (op_signed && src_a[WIDTH-1]) ? -src_a : src_a;
    b_mag = (op_signed && src_b[WIDTH-1]) ? -src_b : src_b;
  end

  // Radix-2 Booth step on {upper, lower, qm1}, followed by an arithmetic shift.
  always_comb begin
    upper = prod[2*WIDTH+1:WIDTH+1];
    case ({prod[0], qm1})
      2'b01:   booth_sum = upper + mcand;
      2'b10:   booth_sum = upper - mcand;
      default: booth_sum = upper;
    endcase
    prod_nxt = {booth_sum[WIDTH], booth_sum, prod[WIDTH:1]};
  end

  restoring_div_step #(.WIDTH(WIDTH)) u_div_step (
    .rem_in  (rem),
    .bit_in  (dvd[WIDTH-1]),
    .divisor (dvs),
    .rem_out (rem_nxt),
    .q_bit   (q_bit)
  );

  always_comb begin
    q_final = {dvd[WIDTH-2:0], q_bit};
    quot_s  = neg_q ? -q_final : q_final;
    rem_s   = neg_r ? -rem_nxt : rem_nxt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      div_zero   <= 1'b0;
      illegal_op <= 1'b0;
      hi         <= '0;
      lo         <= '0;
      prod       <= '0;
      qm1        <= 1'b0;
      mcand      <= '0;
      rem        <= '0;
      dvd        <= '0;
      dvs        <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
    end else begin
      done       <= 1'b0;
      div_zero   <= 1'b0;
      illegal_op <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (!op_legal) begin
              illegal_op <= 1'b1;
            end else begin
              busy <= 1'b1;
              cnt  <= '0;
              if (op_isdiv) begin
                if (src_b == '0) begin
                  state    <= DONE;
                  done     <= 1'b1;
                  div_zero <= 1'b1;
                end else begin
                  state <= DIV;
                  rem   <= '0;
                  dvd   <= a_mag;
                  dvs   <= b_mag;
                  neg_q <= op_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                  neg_r <= op_signed && src_a[WIDTH-1];
                end
              end else begin
                state <= MUL;
                mcand <= {op_signed && src_a[WIDTH-1], src_a};
                prod  <= {{(WIDTH+1){1'b0}}, op_signed && src_b[WIDTH-1], src_b};
                qm1   <= 1'b0;
              end
            end
          end
        end
        MUL: begin
          prod <= prod_nxt;
          qm1  <= prod[0];
          cnt  <= cnt + CW'(1);
          if (cnt == MUL_LAST) begin
            state <= DONE;
            done  <= 1'b1;
            hi    <= prod_nxt[2*WIDTH-1:WIDTH];
            lo    <= prod_nxt[WIDTH-1:0];
          end
        end
        DIV: begin
          rem <= rem_nxt;
          dvd <= q_final;
          cnt <= cnt + CW'(1);
          if (cnt == DIV_LAST) begin
            state <= DONE;
            done  <= 1'b1;
            lo    <= quot_s;
            hi    <= rem_s;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit (WIDTH=32); honours MULTDIV_UNSIGNED_EN.
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        busy, done, div_zero, illegal_op;
  logic [31:0] hi, lo;

  int n_assert = 0;
  int n_fail   = 0;
  int lat, bc;

  mult_div_unit #(.WIDTH(32)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .src_a      (src_a),
    .src_b      (src_b),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero),
    .illegal_op (illegal_op),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request, scramble operands afterwards, and wait (bounded) for done.
  // lat = cycle index of done (0 if never seen), bc = cycles with busy=1 up to done.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit junk_start, output int lat_o, output int bc_o);
    @(negedge clock);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clock);
    start = 1'b0; src_a = ~a; src_b = ~b;
    lat_o = 0; bc_o = 0;
    for (int k = 1; k <= 100; k++) begin
      if (busy) bc_o++;
      if (done) begin
        lat_o = k;
        break;
      end
      start = junk_start && (k >= 5) && (k < 8);
      @(negedge clock);
    end
    start = 1'b0;
  endtask

  task automatic check_idle_after(input string tag);
    @(negedge clock);
    check({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
    check({tag, "_done_after"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_dz",   {31'd0, div_zero}, 32'd0);
    check("rst_ill",  {31'd0, illegal_op}, 32'd0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);

    // 1: MULT 7 * -3, with ignored start pulses while busy
    run_op(2'b00, 32'd7, 32'hFFFF_FFFD, 1'b1, lat, bc);
    check("mult_lat",  32'(lat), 32'd34);
    check("mult_busy", 32'(bc), 32'd34);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFEB);
    check("mult_dz", {31'd0, div_zero}, 32'd0);
    check_idle_after("mult");

    // 2: DIV -7 / 2
    run_op(2'b01, 32'hFFFF_FFF9, 32'd2, 1'b0, lat, bc);
    check("div_lat", 32'(lat), 32'd33);
    check("div_lo", lo, 32'hFFFF_FFFD);
    check("div_hi", hi, 32'hFFFF_FFFF);
    check_idle_after("div");

    // 3: preload hi=0x11 lo=0x22 via 0x451/0x20, then divide by zero
    run_op(2'b01, 32'h451, 32'h20, 1'b0, lat, bc);
    check("pre_lo", lo, 32'h22);
    check("pre_hi", hi, 32'h11);
    run_op(2'b01, 32'd5, 32'd0, 1'b0, lat, bc);
    check("dz_lat", 32'(lat), 32'd1);
    check("dz_flag", {31'd0, div_zero}, 32'd1);
    check("dz_busy", {31'd0, busy}, 32'd1);
    check("dz_hi", hi, 32'h11);
    check("dz_lo", lo, 32'h22);
    @(negedge clock);
    check("dz_flag_after", {31'd0, div_zero}, 32'd0);
    check("dz_busy_after", {31'd0, busy}, 32'd0);

    // 4: MIN / -1 wraps without a flag
    run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, bc);
    check("min_lat", 32'(lat), 32'd33);
    check("min_lo", lo, 32'h8000_0000);
    check("min_hi", hi, 32'h0);
    check("min_dz", {31'd0, div_zero}, 32'd0);

    // 5: reset mid-MULT aborts, then a clean MULT with ignored start pulses
    @(negedge clock);
    start = 1'b1; op = 2'b00; src_a = 32'd5; src_b = 32'd6;
    @(negedge clock);
    start = 1'b0;
    repeat (8) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) seen++;
      @(negedge clock);
    end
    check("abort_no_done", 32'(seen), 32'd0);
    run_op(2'b00, 32'd3, 32'd4, 1'b1, lat, bc);
    check("mult2_lat", 32'(lat), 32'd34);
    check("mult2_lo", lo, 32'd12);
    check("mult2_hi", hi, 32'd0);
    check_idle_after("mult2");

    // 6: unsigned ops
`ifdef MULTDIV_UNSIGNED_EN
    run_op(2'b10, 32'hFFFF_FFFF, 32'd2, 1'b0, lat, bc);
    check("multu_lat", 32'(lat), 32'd34);
    check("multu_hi", hi, 32'h1);
    check("multu_lo", lo, 32'hFFFF_FFFE);
    run_op(2'b11, 32'hFFFF_FFFF, 32'd2, 1'b0, lat, bc);
    check("divu_lat", 32'(lat), 32'd33);
    check("divu_lo", lo, 32'h7FFF_FFFF);
    check("divu_hi", hi, 32'h1);
`else
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      start = 1'b1; op = (i == 0) ? 2'b10 : 2'b11; src_a = 32'hFFFF_FFFF; src_b = 32'd2;
      @(negedge clock);
      start = 1'b0;
      check("ill_pulse", {31'd0, illegal_op}, 32'd1);
      check("ill_busy",  {31'd0, busy}, 32'd0);
      check("ill_done",  {31'd0, done}, 32'd0);
      @(negedge clock);
      check("ill_pulse_after", {31'd0, illegal_op}, 32'd0);
      check("ill_busy_after",  {31'd0, busy}, 32'd0);
      check("ill_hi", hi, 32'd0);
      check("ill_lo", lo, 32'd12);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
